// File: rtl/sram_line_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_line_ctrl_if
//  Description : Cache-side bus of the SRAM line controller. Carries the
//                ICache line-fill handshake and the DCache read/write
//                handshake.
//                master : cache side (drives requests, receives ready/line)
//                slave  : controller side
//  Signals     : i_req/i_addr/i_flush -> i_ready/i_line   (ICache fill)
//                d_req/d_we/d_line_wr/d_addr/d_be/d_wdata
//                                      -> d_ready/d_line  (DCache access)
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_line_ctrl_if #(
    parameter int LINE_WORDS = 4
);
    // ICache line fill
    logic                       i_req;
    logic [31:0]                i_addr;
    logic                       i_flush;
    logic                       i_ready;
    logic [32*LINE_WORDS-1:0]   i_line;
    // DCache access
    logic                       d_req;
    logic                       d_we;
    logic                       d_line_wr;
    logic [31:0]                d_addr;
    logic [3:0]                 d_be;
    logic [32*LINE_WORDS-1:0]   d_wdata;
    logic                       d_ready;
    logic [32*LINE_WORDS-1:0]   d_line;

    modport master (
        output i_req, i_addr, i_flush,
        input  i_ready, i_line,
        output d_req, d_we, d_line_wr, d_addr, d_be, d_wdata,
        input  d_ready, d_line
    );

    modport slave (
        input  i_req, i_addr, i_flush,
        output i_ready, i_line,
        input  d_req, d_we, d_line_wr, d_addr, d_be, d_wdata,
        output d_ready, d_line
    );
endinterface
`default_nettype wire

// File: rtl/sram_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_line_ctrl
//  Description : Arbitrates ICache line fills and DCache accesses onto two
//                asynchronous SRAM banks (base / ext). Each 32-bit word is
//                one slot of WAIT_CYCLES cycles; line operations move
//                LINE_WORDS words, single-word writes move one.
//  Ports       : clk            rising-edge clock
//                rst            asynchronous active-low reset
//                bus            cache-side interface (slave modport)
//                base_* / ext_* SRAM strobes (active low), byte enables,
//                               word address, write data + driver enable,
//                               read data
//  Revision    : 1.0  initial release
// ============================================================================
module sram_line_ctrl #(
    parameter int          LINE_WORDS  = 4,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_TOP    = 32'h8040_0000
) (
    input  logic                clk,
    input  logic                rst,
    sram_line_ctrl_if.slave     bus,
    // base SRAM
    output logic                base_ce_n,
    output logic                base_oe_n,
    output logic                base_we_n,
    output logic [3:0]          base_be_n,
    output logic [19:0]         base_addr,
    output logic [31:0]         base_dq_o,
    output logic                base_dq_oe,
    input  logic [31:0]         base_dq_i,
    // ext SRAM
    output logic                ext_ce_n,
    output logic                ext_oe_n,
    output logic                ext_we_n,
    output logic [3:0]          ext_be_n,
    output logic [19:0]         ext_addr,
    output logic [31:0]         ext_dq_o,
    output logic                ext_dq_oe,
    input  logic [31:0]         ext_dq_i
);

    localparam int          c_IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int          c_CNT_W     = $clog2(WAIT_CYCLES);
    localparam logic [c_IDX_W-1:0] c_LAST_WORD = c_IDX_W'(LINE_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT  = c_CNT_W'(WAIT_CYCLES - 1);
    // Low word-address bits owned by the word index inside a line
    localparam logic [19:0] c_WMASK     = 20'(LINE_WORDS - 1);

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_ACCESS = 2'd1;
    localparam logic [1:0]  c_ST_RET    = 2'd2;

    logic [1:0]                     r_state;
    logic                           r_block;    // IDLE cycle right after RET
    logic                           r_is_d;     // transaction owner: 1 = DCache
    logic                           r_we;
    logic                           r_single;   // single-word write
    logic                           r_ext;      // ext bank selected
    logic [19:0]                    r_waddr;
    logic [3:0]                     r_be;
    logic [LINE_WORDS-1:0][31:0]    r_wdata;
    logic [LINE_WORDS-1:0][31:0]    r_buf;      // read capture, kept off the port lines
    logic [LINE_WORDS-1:0][31:0]    r_i_line;
    logic [LINE_WORDS-1:0][31:0]    r_d_line;
    logic [c_IDX_W-1:0]             r_word;
    logic [c_CNT_W-1:0]             r_cnt;

    logic                           w_d_ext;
    logic                           w_accept_d;
    logic                           w_accept_i;
    logic                           w_flush;
    logic                           w_slot_end;
    logic                           w_last;
    logic                           w_act;
    logic [31:0]                    w_dq_i;
    logic [LINE_WORDS-1:0][31:0]    w_buf_next;
    logic [19:0]                    w_sram_addr;
    logic [31:0]                    w_dq_o;
    logic [3:0]                     w_be_n;
    logic                           w_unused;

    assign w_unused = &{1'b0, bus.i_addr[31:22], bus.i_addr[1:0], bus.d_addr[1:0]};

    // Base SRAM owns [0x8000_0000, BASE_TOP); everything else is ext
    assign w_d_ext    = !((bus.d_addr >= 32'h8000_0000) && (bus.d_addr < BASE_TOP));

    // DCache wins any tie; nothing is accepted in the IDLE cycle after RET
    assign w_accept_d = (r_state == c_ST_IDLE) && !r_block && bus.d_req;
    assign w_accept_i = (r_state == c_ST_IDLE) && !r_block && !bus.d_req && bus.i_req;
    assign w_flush    = (r_state == c_ST_ACCESS) && !r_is_d && bus.i_flush;

    assign w_act      = (r_state == c_ST_ACCESS);
    assign w_slot_end = (r_cnt == c_LAST_CNT);
    assign w_last     = w_slot_end && (r_single || (r_word == c_LAST_WORD));

    assign w_dq_i     = r_ext ? ext_dq_i : base_dq_i;

    // Capture buffer with the current word merged in, so the final word can
    // land in the port line register on the same edge that enters RET
    always_comb begin
        w_buf_next         = r_buf;
        w_buf_next[r_word] = w_dq_i;
    end

    // Line accesses are forced line-aligned; a single-word write keeps its address
    assign w_sram_addr = r_single ? r_waddr : ((r_waddr & ~c_WMASK) | 20'(r_word));
    assign w_dq_o      = r_single ? r_wdata[0] : r_wdata[r_word];
    assign w_be_n      = (r_we && r_single) ? ~r_be : 4'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_block  <= 1'b0;
            r_is_d   <= 1'b0;
            r_we     <= 1'b0;
            r_single <= 1'b0;
            r_ext    <= 1'b0;
            r_waddr  <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_buf    <= '0;
            r_i_line <= '0;
            r_d_line <= '0;
            r_word   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_block <= 1'b0;
                    r_word  <= '0;
                    r_cnt   <= '0;
                    if (w_accept_d) begin
                        r_state  <= c_ST_ACCESS;
                        r_is_d   <= 1'b1;
                        r_we     <= bus.d_we;
                        r_single <= bus.d_we & ~bus.d_line_wr;
                        r_ext    <= w_d_ext;
                        r_waddr  <= bus.d_addr[21:2];
                        r_be     <= bus.d_be;
                        r_wdata  <= bus.d_wdata;
                    end else if (w_accept_i) begin
                        r_state  <= c_ST_ACCESS;
                        r_is_d   <= 1'b0;
                        r_we     <= 1'b0;
                        r_single <= 1'b0;
                        r_ext    <= 1'b0;
                        r_waddr  <= bus.i_addr[21:2];
                    end
                end
                c_ST_ACCESS: begin
                    if (w_flush) begin
                        // Abandon the fill; i_line keeps its previous contents
                        r_state <= c_ST_IDLE;
                    end else if (w_slot_end) begin
                        r_cnt <= '0;
                        if (!r_we) begin
                            r_buf <= w_buf_next;
                        end
                        if (w_last) begin
                            r_state <= c_ST_RET;
                            if (!r_we) begin
                                if (r_is_d) begin
                                    r_d_line <= w_buf_next;
                                end else begin
                                    r_i_line <= w_buf_next;
                                end
                            end
                        end else begin
                            r_word <= r_word + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RET: begin
                    r_state <= c_ST_IDLE;
                    r_block <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state registers, so the asynchronous
    // reset releases every SRAM pin without waiting for a clock edge
    always_comb begin
        base_ce_n  = 1'b1;
        base_oe_n  = 1'b1;
        base_we_n  = 1'b1;
        base_be_n  = 4'hF;
        base_addr  = '0;
        base_dq_o  = '0;
        base_dq_oe = 1'b0;
        ext_ce_n   = 1'b1;
        ext_oe_n   = 1'b1;
        ext_we_n   = 1'b1;
        ext_be_n   = 4'hF;
        ext_addr   = '0;
        ext_dq_o   = '0;
        ext_dq_oe  = 1'b0;
        if (w_act) begin
            if (r_ext) begin
                ext_ce_n   = 1'b0;
                ext_oe_n   = r_we;
                // Last cycle of a write slot is write recovery
                ext_we_n   = !(r_we && !w_slot_end);
                ext_be_n   = w_be_n;
                ext_addr   = w_sram_addr;
                ext_dq_o   = r_we ? w_dq_o : 32'h0;
                ext_dq_oe  = r_we;
            end else begin
                base_ce_n  = 1'b0;
                base_oe_n  = r_we;
                base_we_n  = !(r_we && !w_slot_end);
                base_be_n  = w_be_n;
                base_addr  = w_sram_addr;
                base_dq_o  = r_we ? w_dq_o : 32'h0;
                base_dq_oe = r_we;
            end
        end
    end

    assign bus.i_ready = (r_state == c_ST_RET) && !r_is_d;
    assign bus.d_ready = (r_state == c_ST_RET) && r_is_d;
    assign bus.i_line  = r_i_line;
    assign bus.d_line  = r_d_line;

endmodule
`default_nettype wire

// File: tb/tb_sram_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_line_ctrl
//  Description : Scoreboard bench for sram_line_ctrl (LINE_WORDS=4,
//                WAIT_CYCLES=2). Directed stimulus pushes the expected SRAM
//                word slots and ready responses; two monitors pop and compare
//                whenever the DUT presents an SRAM slot or a ready pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_line_ctrl;

    localparam int LW = 4;
    localparam logic [127:0] c_LINE_A  = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    localparam logic [127:0] c_LINE_E  = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
    localparam logic [127:0] c_LINE_B0 = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    localparam logic [127:0] c_WD      = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_line_ctrl_if #(.LINE_WORDS(LW)) bus();

    logic        base_ce_n, base_oe_n, base_we_n, base_dq_oe;
    logic [3:0]  base_be_n;
    logic [19:0] base_addr;
    logic [31:0] base_dq_o, base_dq_i;
    logic        ext_ce_n, ext_oe_n, ext_we_n, ext_dq_oe;
    logic [3:0]  ext_be_n;
    logic [19:0] ext_addr;
    logic [31:0] ext_dq_o, ext_dq_i;

    logic [31:0] base_mem [16];
    logic [31:0] ext_mem  [16];
    assign base_dq_i = base_mem[base_addr[3:0]];
    assign ext_dq_i  = ext_mem[ext_addr[3:0]];

    sram_line_ctrl #(.LINE_WORDS(LW), .WAIT_CYCLES(2), .BASE_TOP(32'h8040_0000)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .bus        (bus),
        .base_ce_n  (base_ce_n),
        .base_oe_n  (base_oe_n),
        .base_we_n  (base_we_n),
        .base_be_n  (base_be_n),
        .base_addr  (base_addr),
        .base_dq_o  (base_dq_o),
        .base_dq_oe (base_dq_oe),
        .base_dq_i  (base_dq_i),
        .ext_ce_n   (ext_ce_n),
        .ext_oe_n   (ext_oe_n),
        .ext_we_n   (ext_we_n),
        .ext_be_n   (ext_be_n),
        .ext_addr   (ext_addr),
        .ext_dq_o   (ext_dq_o),
        .ext_dq_oe  (ext_dq_oe),
        .ext_dq_i   (ext_dq_i)
    );

    typedef struct {
        bit           is_d;
        logic [127:0] line;
        int           cyc;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [63:0] acc_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Slot signature: {pad, ext, dq_oe, oe_n, we_n(first cycle), other bank idle, addr, be_n, data}
    function automatic logic [63:0] acc(input bit ext, input bit wr, input logic [19:0] a,
                                        input logic [3:0] ben, input logic [31:0] d);
        return {3'b000, ext, wr, wr, ~wr, 1'b1, a, ben, d};
    endfunction

    task automatic push_acc(input bit ext, input bit wr, input logic [19:0] a,
                            input logic [3:0] ben, input logic [31:0] d);
        acc_q.push_back(acc(ext, wr, a, ben, d));
    endtask

    task automatic push_rsp(input bit is_d, input logic [127:0] line, input int c);
        rsp_t r;
        r.is_d = is_d;
        r.line = line;
        r.cyc  = c;
        rsp_q.push_back(r);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SRAM slot monitor: compares the first cycle of each 2-cycle slot,
    // checks write recovery on the second
    initial begin : mon_sram
        int          slot;
        logic        s_ext, s_oe, s_oen, s_wen, s_other;
        logic [19:0] s_a;
        logic [3:0]  s_be;
        logic [31:0] s_d;
        logic [63:0] obs;
        logic [63:0] e;
        slot = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (!base_ce_n || !ext_ce_n)) begin
                if (!ext_ce_n) begin
                    s_ext = 1'b1; s_oe = ext_dq_oe; s_oen = ext_oe_n; s_wen = ext_we_n;
                    s_a = ext_addr; s_be = ext_be_n; s_d = ext_dq_o;
                    s_other = base_ce_n & base_oe_n & base_we_n & (base_be_n == 4'hF) & ~base_dq_oe;
                end else begin
                    s_ext = 1'b0; s_oe = base_dq_oe; s_oen = base_oe_n; s_wen = base_we_n;
                    s_a = base_addr; s_be = base_be_n; s_d = base_dq_o;
                    s_other = ext_ce_n & ext_oe_n & ext_we_n & (ext_be_n == 4'hF) & ~ext_dq_oe;
                end
                if (slot == 0) begin
                    obs = {3'b000, s_ext, s_oe, s_oen, s_wen, s_other, s_a, s_be, (s_oe ? s_d : 32'h0)};
                    if (acc_q.size() == 0) begin
                        chk("spurious_sram_access", 128'(obs), 128'(0));
                    end else begin
                        e = acc_q.pop_front();
                        chk("sram_slot", 128'(obs), 128'(e));
                    end
                end else begin
                    chk("slot_last_we_n_high", 128'(s_wen), 128'(1));
                end
                slot = (slot + 1) % 2;
            end else begin
                slot = 0;
            end
        end
    end

    // Ready monitor: pops one expected response per ready pulse
    initial begin : mon_rdy
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.i_ready || bus.d_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("spurious_ready", 128'({bus.i_ready, bus.d_ready}), 128'(0));
                end else begin
                    e = rsp_q.pop_front();
                    chk("ready_port", 128'({bus.i_ready, bus.d_ready}), 128'(e.is_d ? 2'b01 : 2'b10));
                    chk("ready_cycle", 128'(cyc), 128'(e.cyc));
                    chk("ready_line", e.is_d ? bus.d_line : bus.i_line, e.line);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ICache fill of 0x8000_0014: base words 4..7, line {44,33,22,11}
    task automatic ifill_14();
        int t;
        t = cyc;
        for (int k = 0; k < 4; k++) push_acc(1'b0, 1'b0, 20'(4 + k), 4'h0, 32'h0);
        push_rsp(1'b0, c_LINE_A, t + 9);
        bus.i_addr = 32'h8000_0014;
        bus.i_req  = 1'b1;
        tick(10);
        bus.i_req  = 1'b0;
        tick(2);
    endtask

    initial begin : stim
        int t;
        for (int i = 0; i < 16; i++) begin
            base_mem[i] = 32'hB000_0000 + 32'(i);
            ext_mem[i]  = 32'hE000_0000 + 32'(i);
        end
        base_mem[4] = 32'h11; base_mem[5] = 32'h22; base_mem[6] = 32'h33; base_mem[7] = 32'h44;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_line_wr = 1'b0;
        bus.d_addr = '0; bus.d_be = '0; bus.d_wdata = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_strobes", 128'({base_ce_n, base_oe_n, base_we_n, ext_ce_n, ext_oe_n, ext_we_n}), 128'(6'h3F));
        chk("rst_be_n", 128'({base_be_n, ext_be_n}), 128'(8'hFF));
        chk("rst_addr", 128'({base_addr, ext_addr}), 128'(0));
        chk("rst_dq", 128'({base_dq_o, ext_dq_o, base_dq_oe, ext_dq_oe}), 128'(0));
        chk("rst_ready", 128'({bus.i_ready, bus.d_ready}), 128'(0));
        chk("rst_i_line", bus.i_line, 128'(0));
        chk("rst_d_line", bus.d_line, 128'(0));
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // ICache fill
        ifill_14();

        // Collision: DCache ext read first, ICache fill at T+11
        t = cyc;
        for (int k = 0; k < 4; k++) push_acc(1'b1, 1'b0, 20'(k), 4'h0, 32'h0);
        push_rsp(1'b1, c_LINE_E, t + 9);
        for (int k = 0; k < 4; k++) push_acc(1'b0, 1'b0, 20'(16 + k), 4'h0, 32'h0);
        push_rsp(1'b0, c_LINE_B0, t + 20);
        bus.d_we = 1'b0; bus.d_addr = 32'h8040_0000; bus.d_req = 1'b1;
        bus.i_addr = 32'h8000_0040; bus.i_req = 1'b1;
        tick(10);
        bus.d_req = 1'b0;
        tick(11);
        bus.i_req = 1'b0;
        tick(2);

        // Single-word write to ext, d_line untouched
        t = cyc;
        push_acc(1'b1, 1'b1, 20'h40002, 4'b1100, 32'hDEAD_BEEF);
        push_rsp(1'b1, c_LINE_E, t + 3);
        bus.d_we = 1'b1; bus.d_line_wr = 1'b0; bus.d_addr = 32'h8050_0008; bus.d_be = 4'b0011;
        bus.d_wdata = {96'h1234_5678_9ABC_DEF0_1122_3344, 32'hDEAD_BEEF};
        bus.d_req = 1'b1;
        tick(4);
        bus.d_req = 1'b0;
        tick(2);

        // Line write to base from an unaligned address, be ignored
        t = cyc;
        for (int k = 0; k < 4; k++) push_acc(1'b0, 1'b1, 20'(8 + k), 4'h0, 32'hC0DE_0000 + 32'(k));
        push_rsp(1'b1, c_LINE_E, t + 9);
        bus.d_we = 1'b1; bus.d_line_wr = 1'b1; bus.d_addr = 32'h8000_002C; bus.d_be = 4'b0101;
        bus.d_wdata = c_WD;
        bus.d_req = 1'b1;
        tick(10);
        bus.d_req = 1'b0;
        tick(2);

        // Flush in word 2 of an ICache fill
        t = cyc;
        for (int k = 0; k < 3; k++) push_acc(1'b0, 1'b0, 20'(8 + k), 4'h0, 32'h0);
        bus.i_addr = 32'h8000_0024; bus.i_req = 1'b1;
        tick(5);
        bus.i_flush = 1'b1; bus.i_req = 1'b0;
        tick(1);
        chk("flush_strobes_high", 128'({base_ce_n, base_oe_n, base_we_n, ext_ce_n}), 128'(4'hF));
        chk("flush_i_line_kept", bus.i_line, c_LINE_B0);
        bus.i_flush = 1'b0;
        tick(12);
        ifill_14();

        // Asynchronous reset during an ext line write
        t = cyc;
        push_acc(1'b1, 1'b1, 20'h80000, 4'h0, 32'hC0DE_0000);
        bus.d_we = 1'b1; bus.d_line_wr = 1'b1; bus.d_addr = 32'h8060_0000; bus.d_wdata = c_WD;
        bus.d_req = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk("async_rst_ext_pins", 128'({ext_ce_n, ext_we_n, ext_oe_n, ext_dq_oe}), 128'(4'b1110));
        chk("async_rst_lines", {bus.i_line ^ bus.d_line, bus.i_line[63:0] | bus.d_line[63:0]}, 128'(0));
        tick(2);
        rst_n = 1'b1;
        tick(12);

        // i_req, d_req and i_flush together: DCache served, flush ignored
        t = cyc;
        for (int k = 0; k < 4; k++) push_acc(1'b1, 1'b0, 20'(k), 4'h0, 32'h0);
        push_rsp(1'b1, c_LINE_E, t + 9);
        for (int k = 0; k < 4; k++) push_acc(1'b0, 1'b0, 20'(4 + k), 4'h0, 32'h0);
        push_rsp(1'b0, c_LINE_A, t + 20);
        bus.d_we = 1'b0; bus.d_line_wr = 1'b0; bus.d_addr = 32'h8040_0000;
        bus.i_addr = 32'h8000_0014;
        bus.d_req = 1'b1; bus.i_req = 1'b1; bus.i_flush = 1'b1;
        tick(9);
        bus.i_flush = 1'b0;
        tick(1);
        bus.d_req = 1'b0;
        tick(11);
        bus.i_req = 1'b0;
        tick(3);

        chk("sb_rsp_left", 128'(rsp_q.size()), 128'(0));
        chk("sb_acc_left", 128'(acc_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
